// File: rtl/siphash_pkg.sv
// Shared SipHash definitions: initialisation constants, finalisation XOR,
// controller state encoding, datapath widths and a 64-bit rotate helper.
package siphash_pkg;

  localparam int unsigned KEY_W      = 128;
  localparam int unsigned WORD_W     = 64;
  localparam int unsigned BYTES_W    = 4;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned WORD_BYTES = 8;

  localparam logic [WORD_W-1:0] IV0 = 64'h736f6d6570736575;
  localparam logic [WORD_W-1:0] IV1 = 64'h646f72616e646f6d;
  localparam logic [WORD_W-1:0] IV2 = 64'h6c7967656e657261;
  localparam logic [WORD_W-1:0] IV3 = 64'h7465646279746573;

  localparam logic [WORD_W-1:0] FINAL_XOR = 64'h0000_0000_0000_00ff;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MSG,
    COMPRESS,
    FINAL,
    DONE
  } state_e;

  function automatic logic [WORD_W-1:0] rotl64(input logic [WORD_W-1:0] x,
                                               input int unsigned s);
    return (x << s) | (x >> (WORD_W - s));
  endfunction

endpackage

// File: rtl/siphash_ctrl_if.sv
// Host-side bus of the SipHash sequencer: key request, message word stream
// and tag return, each a valid/ready handshake, plus the busy flag.
//   master : host side (drives key, message words, hash_ready)
//   slave  : siphash_ctrl side
interface siphash_ctrl_if;
  import siphash_pkg::*;

  logic [KEY_W-1:0]   key_i;
  logic               key_valid;
  logic               key_ready;
  logic [WORD_W-1:0]  msg_data;
  logic [BYTES_W-1:0] msg_bytes;
  logic               msg_last;
  logic               msg_valid;
  logic               msg_ready;
  logic [WORD_W-1:0]  hash_o;
  logic               hash_valid;
  logic               hash_ready;
  logic               busy;

  modport master (
    output key_i, key_valid, msg_data, msg_bytes, msg_last, msg_valid, hash_ready,
    input  key_ready, msg_ready, hash_o, hash_valid, busy
  );

  modport slave (
    input  key_i, key_valid, msg_data, msg_bytes, msg_last, msg_valid, hash_ready,
    output key_ready, msg_ready, hash_o, hash_valid, busy
  );

endinterface

// File: rtl/sip_round.sv
// One SipRound split into two registered half-rounds (latency 2 cycles).
// Free-running pipeline with no valid tracking; the caller decides which
// output cycle is meaningful.
//   clk, rst_n   : clock, asynchronous active-low reset
//   v0_i..v3_i   : state into the round
//   v0_o..v3_o   : state after the full round, registered
module sip_round
  import siphash_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] v0_i,
  input  logic [WORD_W-1:0] v1_i,
  input  logic [WORD_W-1:0] v2_i,
  input  logic [WORD_W-1:0] v3_i,
  output logic [WORD_W-1:0] v0_o,
  output logic [WORD_W-1:0] v1_o,
  output logic [WORD_W-1:0] v2_o,
  output logic [WORD_W-1:0] v3_o
);

  logic [WORD_W-1:0] s0_d, s1_d, s2_d, s3_d;
  logic [WORD_W-1:0] s0_q, s1_q, s2_q, s3_q;
  logic [WORD_W-1:0] o0_d, o1_d, o2_d, o3_d;
  logic [WORD_W-1:0] o0_q, o1_q, o2_q, o3_q;
  logic [WORD_W-1:0] a0, c2;

  always_comb begin
    s0_d = v0_i + v1_i;
    s1_d = rotl64(v1_i, 13) ^ s0_d;
    s0_d = rotl64(s0_d, 32);
    s2_d = v2_i + v3_i;
    s3_d = rotl64(v3_i, 16) ^ s2_d;
  end

  always_comb begin
    a0   = s0_q + s3_q;
    o3_d = rotl64(s3_q, 21) ^ a0;
    o0_d = a0;
    c2   = s2_q + s1_q;
    o1_d = rotl64(s1_q, 17) ^ c2;
    o2_d = rotl64(c2, 32);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      o0_q <= '0;
      o1_q <= '0;
      o2_q <= '0;
      o3_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      o0_q <= o0_d;
      o1_q <= o1_d;
      o2_q <= o2_d;
      o3_q <= o3_d;
    end
  end

  assign v0_o = o0_q;
  assign v1_o = o1_q;
  assign v2_o = o2_q;
  assign v3_o = o3_q;

endmodule

// File: rtl/siphash_ctrl.sv
// Iterative SipHash-c-d sequencer around one pipelined sip_round.
// Takes a 128-bit key, a stream of 64-bit little-endian message words
// (tail word padded with the total length byte), runs C_ROUNDS per block
// and D_ROUNDS of finalisation, and returns the 64-bit tag.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : key / message / tag handshakes and busy (slave side)
module siphash_ctrl
  import siphash_pkg::*;
#(
  parameter int unsigned C_ROUNDS  = 2,
  parameter int unsigned D_ROUNDS  = 4,
  parameter int unsigned ROUND_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  siphash_ctrl_if.slave  bus
);

  localparam int unsigned RND_MAX = (C_ROUNDS > D_ROUNDS) ? C_ROUNDS : D_ROUNDS;
  localparam int unsigned RND_W   = $clog2(RND_MAX + 1);
  localparam int unsigned LAT_W   = $clog2(ROUND_LAT) + 1;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  v0_q, v1_q, v2_q, v3_q;
  logic [WORD_W-1:0]  v0_d, v1_d, v2_d, v3_d;
  logic [WORD_W-1:0]  m_q, m_d;
  logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
  logic [RND_W-1:0]   rnd_cnt_q, rnd_cnt_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic               pad_pend_q, pad_pend_d;
  logic               last_q, last_d;
  logic [WORD_W-1:0]  hash_q, hash_d;
  logic               hash_valid_q, hash_valid_d;

  logic [WORD_W-1:0]  r0, r1, r2, r3;
  logic [WORD_W-1:0]  masked;
  logic [LEN_W-1:0]   tail_len;
  logic [WORD_W-1:0]  short_blk;
  logic [WORD_W-1:0]  pad_blk;
  logic [WORD_W-1:0]  blk;
  logic               round_done;

  // The round is fed v*_d, so its first half-round is captured on the same
  // edge that loads v*_q; each round therefore costs exactly ROUND_LAT cycles
  // and the next one starts on the writeback edge.
  sip_round u_round (
    .clk   (clk),
    .rst_n (~rst),
    .v0_i  (v0_d),
    .v1_i  (v1_d),
    .v2_i  (v2_d),
    .v3_i  (v3_d),
    .v0_o  (r0),
    .v1_o  (r1),
    .v2_o  (r2),
    .v3_o  (r3)
  );

  // Tail block for a short final word: keep bytes below msg_bytes and put
  // the running length (mod 256) in the top byte.
  always_comb begin
    masked   = '0;
    tail_len = len_cnt_q + LEN_W'(bus.msg_bytes);
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (i < 32'(bus.msg_bytes)) masked[i*8 +: 8] = bus.msg_data[i*8 +: 8];
    end
    short_blk = masked | {tail_len, 56'b0};
    pad_blk   = {len_cnt_q, 56'b0};
  end

  assign round_done = (lat_cnt_q == LAT_W'(ROUND_LAT - 1));

  always_comb begin
    state_d      = state_q;
    v0_d         = v0_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    v3_d         = v3_q;
    m_d          = m_q;
    len_cnt_d    = len_cnt_q;
    rnd_cnt_d    = rnd_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    pad_pend_d   = pad_pend_q;
    last_d       = last_q;
    hash_d       = hash_q;
    hash_valid_d = hash_valid_q;
    blk          = bus.msg_data;

    unique case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          v0_d       = bus.key_i[63:0]   ^ IV0;
          v1_d       = bus.key_i[127:64] ^ IV1;
          v2_d       = bus.key_i[63:0]   ^ IV2;
          v3_d       = bus.key_i[127:64] ^ IV3;
          len_cnt_d  = '0;
          pad_pend_d = 1'b0;
          state_d    = WAIT_MSG;
        end
      end

      WAIT_MSG: begin
        if (bus.msg_valid) begin
          if (!bus.msg_last) begin
            blk       = bus.msg_data;
            len_cnt_d = len_cnt_q + 8'd8;
          end else if (bus.msg_bytes >= 4'd8) begin
            // Full final word: the length goes into a separate pad block.
            blk        = bus.msg_data;
            len_cnt_d  = len_cnt_q + 8'd8;
            pad_pend_d = 1'b1;
          end else begin
            blk = short_blk;
          end
          last_d    = bus.msg_last;
          m_d       = blk;
          v3_d      = v3_q ^ blk;
          rnd_cnt_d = '0;
          lat_cnt_d = '0;
          state_d   = COMPRESS;
        end
      end

      COMPRESS: begin
        if (round_done) begin
          v0_d      = r0;
          v1_d      = r1;
          v2_d      = r2;
          v3_d      = r3;
          lat_cnt_d = '0;
          if (rnd_cnt_q == RND_W'(C_ROUNDS - 1)) begin
            v0_d      = r0 ^ m_q;
            rnd_cnt_d = '0;
            if (pad_pend_q) begin
              m_d        = pad_blk;
              v3_d       = r3 ^ pad_blk;
              pad_pend_d = 1'b0;
            end else if (last_q) begin
              v2_d    = r2 ^ FINAL_XOR;
              state_d = FINAL;
            end else begin
              state_d = WAIT_MSG;
            end
          end else begin
            rnd_cnt_d = rnd_cnt_q + RND_W'(1);
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end

      FINAL: begin
        // rnd_cnt reaching D_ROUNDS marks the cycle after the last writeback.
        if (rnd_cnt_q == RND_W'(D_ROUNDS)) begin
          hash_d       = v0_q ^ v1_q ^ v2_q ^ v3_q;
          hash_valid_d = 1'b1;
          state_d      = DONE;
        end else if (round_done) begin
          v0_d      = r0;
          v1_d      = r1;
          v2_d      = r2;
          v3_d      = r3;
          lat_cnt_d = '0;
          rnd_cnt_d = rnd_cnt_q + RND_W'(1);
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end

      DONE: begin
        if (bus.hash_ready) begin
          hash_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      v0_q         <= '0;
      v1_q         <= '0;
      v2_q         <= '0;
      v3_q         <= '0;
      m_q          <= '0;
      len_cnt_q    <= '0;
      rnd_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      pad_pend_q   <= 1'b0;
      last_q       <= 1'b0;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      v3_q         <= v3_d;
      m_q          <= m_d;
      len_cnt_q    <= len_cnt_d;
      rnd_cnt_q    <= rnd_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      pad_pend_q   <= pad_pend_d;
      last_q       <= last_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
    end
  end

  assign bus.key_ready  = (state_q == IDLE);
  assign bus.msg_ready  = (state_q == WAIT_MSG);
  assign bus.busy       = (state_q != IDLE);
  assign bus.hash_o     = hash_q;
  assign bus.hash_valid = hash_valid_q;

endmodule

// File: tb/tb_siphash_ctrl.sv
module tb_siphash_ctrl;
  import siphash_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  siphash_ctrl_if bus();

  siphash_ctrl #(.C_ROUNDS(2), .D_ROUNDS(4), .ROUND_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int          ready_viol = 0;
  int          quiet = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  model_bytes[$];
  logic [63:0] mv[4];

  localparam logic [127:0] KEY_STD = 128'h0f0e0d0c0b0a09080706050403020100;

  always @(posedge clk) cyc <= cyc + 1;

  // After an accepted word the DUT must be compressing for at least 4 cycles.
  always @(posedge clk) begin
    if (bus.msg_valid && bus.msg_ready) quiet <= 4;
    else if (quiet > 0) quiet <= quiet - 1;
  end

  always @(negedge clk) begin
    if (!rst && bus.msg_ready &&
        (bus.key_ready || bus.hash_valid || !bus.busy || quiet > 0))
      ready_viol <= ready_viol + 1;
  end

  always @(posedge clk) begin
    if (bus.msg_valid)
      assert (bus.msg_bytes <= 4'd8) else $error("FAIL msg_bytes illegal: %0d", bus.msg_bytes);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned s);
    return (x << s) | (x >> (64 - s));
  endfunction

  function automatic void m_round();
    mv[0] = mv[0] + mv[1]; mv[1] = rotl(mv[1], 13); mv[1] ^= mv[0]; mv[0] = rotl(mv[0], 32);
    mv[2] = mv[2] + mv[3]; mv[3] = rotl(mv[3], 16); mv[3] ^= mv[2];
    mv[0] = mv[0] + mv[3]; mv[3] = rotl(mv[3], 21); mv[3] ^= mv[0];
    mv[2] = mv[2] + mv[1]; mv[1] = rotl(mv[1], 17); mv[1] ^= mv[2]; mv[2] = rotl(mv[2], 32);
  endfunction

  // Reference SipHash-2-4 over the byte string in model_bytes.
  function automatic logic [63:0] model_hash(input logic [127:0] key);
    logic [63:0] k0, k1, b;
    int n, nblk;
    k0 = key[63:0];
    k1 = key[127:64];
    mv[0] = k0 ^ 64'h736f6d6570736575;
    mv[1] = k1 ^ 64'h646f72616e646f6d;
    mv[2] = k0 ^ 64'h6c7967656e657261;
    mv[3] = k1 ^ 64'h7465646279746573;
    n = model_bytes.size();
    nblk = n / 8;
    for (int i = 0; i < nblk; i++) begin
      b = '0;
      for (int j = 0; j < 8; j++) b[8*j +: 8] = model_bytes[8*i + j];
      mv[3] ^= b;
      m_round(); m_round();
      mv[0] ^= b;
    end
    b = '0;
    b[63:56] = n[7:0];
    for (int j = 0; j < n % 8; j++) b[8*j +: 8] = model_bytes[8*nblk + j];
    mv[3] ^= b;
    m_round(); m_round();
    mv[0] ^= b;
    mv[2] ^= 64'hff;
    for (int r = 0; r < 4; r++) m_round();
    return mv[0] ^ mv[1] ^ mv[2] ^ mv[3];
  endfunction

  task automatic do_key(input logic [127:0] key);
    bit done = 0;
    bus.key_i = key;
    bus.key_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.key_ready) done = 1;
      @(posedge clk); #1;
    end
    bus.key_valid = 1'b0;
    if (!done) chk("key_timeout", 64'd0, 64'd1);
  endtask

  // Sends model_bytes as words; pushes the expected tag to the scoreboard.
  task automatic send_msg(input logic [63:0] exp, input bit gaps, input bit junk,
                          output int unsigned acc_cyc);
    int n, nw, nb;
    bit done;
    logic [63:0] word;
    n  = model_bytes.size();
    nw = (n == 0) ? 1 : (n + 7) / 8;
    exp_q.push_back(exp);
    acc_cyc = 0;
    for (int w = 0; w < nw; w++) begin
      nb = n - 8*w;
      if (nb > 8) nb = 8;
      word = '0;
      for (int j = 0; j < nb; j++) word[8*j +: 8] = model_bytes[8*w + j];
      if (junk) for (int j = nb; j < 8; j++) word[8*j +: 8] = 8'($urandom);
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      bus.msg_data  = word;
      bus.msg_bytes = 4'(nb);
      bus.msg_last  = (w == nw - 1);
      bus.msg_valid = 1'b1;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
        if (bus.msg_ready) done = 1;
        @(posedge clk); #1;
      end
      bus.msg_valid = 1'b0;
      if (!done) begin
        chk("msg_timeout", 64'd0, 64'd1);
        return;
      end
      acc_cyc = cyc;
    end
  endtask

  task automatic wait_hash(input string tag, input int exp_lat, input int unsigned acc,
                           input int hold);
    bit seen = 0;
    logic [63:0] exp;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    exp = exp_q.pop_front();
    bus.hash_ready = (hold == 0);
    for (int i = 0; i < 300 && !seen; i++) begin
      if (bus.hash_valid) seen = 1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      bus.hash_ready = 1'b1;
      return;
    end
    if (exp_lat >= 0) chk({tag, "_latency"}, 64'(cyc - acc), 64'(exp_lat));
    if (hold > 0) begin
      bus.key_i = {$urandom, $urandom, $urandom, $urandom};
      bus.key_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, "_hold_hash"}, bus.hash_o, exp);
        chk({tag, "_hold_valid"}, 64'(bus.hash_valid), 64'd1);
        chk({tag, "_hold_keyrdy"}, 64'(bus.key_ready), 64'd0);
      end
      bus.key_valid = 1'b0;
      bus.hash_ready = 1'b1;
    end
    chk(tag, bus.hash_o, exp);
    @(posedge clk); #1;
    chk({tag, "_idle_keyrdy"}, 64'(bus.key_ready), 64'd1);
    chk({tag, "_idle_valid"}, 64'(bus.hash_valid), 64'd0);
    chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_key_ready"}, 64'(bus.key_ready), 64'd1);
    chk({tag, "_msg_ready"}, 64'(bus.msg_ready), 64'd0);
    chk({tag, "_hash_valid"}, 64'(bus.hash_valid), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_hash_o"}, bus.hash_o, 64'd0);
  endtask

  task automatic load_seq(input int n);
    model_bytes.delete();
    for (int i = 0; i < n; i++) model_bytes.push_back(8'(i));
  endtask

  int unsigned acc;

  initial begin
    bus.key_i      = '0;
    bus.key_valid  = 1'b0;
    bus.msg_data   = '0;
    bus.msg_bytes  = '0;
    bus.msg_last   = 1'b0;
    bus.msg_valid  = 1'b0;
    bus.hash_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: empty message, junk in unused bytes must be masked
    load_seq(0);
    do_key(KEY_STD);
    chk("wait_busy", 64'(bus.busy), 64'd1);
    chk("wait_msg_ready", 64'(bus.msg_ready), 64'd1);
    send_msg(64'h726fdb47dd0e0e31, 1'b0, 1'b1, acc);
    wait_hash("t1_empty", -1, acc, 0);

    // 2: 15-byte message, latency from last accept
    load_seq(15);
    do_key(KEY_STD);
    send_msg(64'ha129ca6149be45e5, 1'b0, 1'b0, acc);
    wait_hash("t2_15b", 13, acc, 0);

    // 3: exactly 8 bytes, separate pad block
    load_seq(8);
    do_key(KEY_STD);
    send_msg(model_hash(KEY_STD), 1'b0, 1'b0, acc);
    wait_hash("t3_8b", -1, acc, 0);

    // 4: tag held under back-pressure, key requests ignored in DONE
    load_seq(3);
    do_key(KEY_STD);
    send_msg(model_hash(KEY_STD), 1'b0, 1'b1, acc);
    wait_hash("t4_hold", -1, acc, 20);

    // 5: reset in the middle of compression, then a clean rerun
    load_seq(15);
    do_key(KEY_STD);
    send_msg(64'ha129ca6149be45e5, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_midrst");
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_key(KEY_STD);
    send_msg(64'ha129ca6149be45e5, 1'b0, 1'b0, acc);
    wait_hash("t5_rerun", 13, acc, 0);

    // 6: 320 random bytes (length byte wraps to 0x40) with input gaps
    begin
      logic [127:0] k;
      k = {$urandom, $urandom, $urandom, $urandom};
      model_bytes.delete();
      for (int i = 0; i < 320; i++) model_bytes.push_back(8'($urandom));
      do_key(k);
      send_msg(model_hash(k), 1'b1, 1'b0, acc);
      wait_hash("t6_long", 13 + 4, acc, 0);
    end

    chk("msg_ready_exclusive", 64'(ready_viol), 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
